// File: rtl/ddr_rx_deframer_pkg.sv
// Shared definitions for the HDR-DDR receive deframer and the CRC-5 engine.
// Holds the FSM encoding, error codes, frame constants and parity/CRC helpers.
package ddr_rx_deframer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_PREAMBLE  = 4'd1,
      ST_DATA      = 4'd2,
      ST_PARITY    = 4'd3,
      ST_COMMIT_HI = 4'd4,
      ST_COMMIT_LO = 4'd5,
      ST_CRC_TOKEN = 4'd6,
      ST_CRC_VAL   = 4'd7,
      ST_CHECK     = 4'd8
   } state_e;

   localparam logic [3:0] ERR_NONE   = 4'd0;
   localparam logic [3:0] ERR_PARITY = 4'd1;
   localparam logic [3:0] ERR_CRC    = 4'd2;
   localparam logic [3:0] ERR_FRAME  = 4'd3;

   localparam logic [1:0] PRE_DATA  = 2'b10;
   localparam logic [1:0] PRE_CRC   = 2'b01;
   localparam logic [3:0] CRC_TOKEN = 4'hC;
   localparam logic [4:0] CRC5_POLY = 5'h05;
   localparam logic [4:0] CRC_INIT  = 5'h1F;

   // {P1, P0}: P1 is odd parity over odd bits, P0 is inverted parity over even bits
   function automatic logic [1:0] word_parity(input logic [15:0] w);
      return {^(w & 16'hAAAA), ~^(w & 16'h5555)};
   endfunction

   function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
      logic [4:0] c;
      logic       fb;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         fb = c[4] ^ data[i];
         c  = {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
      end
      return c;
   endfunction

endpackage

// File: rtl/ddr_rx_deframer_crc5.sv
// Byte-serial CRC-5 (x^5+x^2+1), MSB first, with clear and byte strobe.
// Shared between the Rx deframer and the Tx framer.
module ddr_crc5 #(
   parameter logic [4:0] INIT = 5'h1F
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic [4:0] crc
);
   import ddr_rx_deframer_pkg::*;

   logic [4:0] crc_r;
   logic [4:0] crc_nx_s;

   // next CRC value: reseed on clear, fold in one byte when strobed
   always_comb begin
      crc_nx_s = crc_r;
      if (clr) begin
         crc_nx_s = INIT;
      end else if (byte_valid) begin
         crc_nx_s = crc5_byte(crc_r, byte_data);
      end else begin
         crc_nx_s = crc_r;
      end
   end

   // CRC register
   always_ff @(posedge clk) begin
      if (rst) begin
         crc_r <= INIT;
      end else begin
         crc_r <= crc_nx_s;
      end
   end

   assign crc = crc_r;

endmodule

// File: rtl/ddr_rx_deframer.sv
// HDR-DDR receive deframer: strips preamble, checks word parity, writes bytes
// into the register file and verifies the closing CRC-5 word.
module ddr_rx_deframer #(
   parameter int         ADDR_W   = 10,
   parameter int         LEN_W    = 16,
   parameter logic [4:0] CRC_INIT = ddr_rx_deframer_pkg::CRC_INIT
) (
   input  logic              i_sys_clk,
   input  logic              i_sys_rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [LEN_W-1:0]  i_data_len,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic              i_bit_valid,
   input  logic              i_sda_bit,
   output logic              o_regf_wr_en,
   output logic [ADDR_W-1:0] o_regf_addr,
   output logic [7:0]        o_regf_rx_data,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_early_term,
   output logic              o_error,
   output logic [3:0]        o_error_type
);
   import ddr_rx_deframer_pkg::*;

   state_e state_r, state_nx_s;
   logic [LEN_W-1:0]  rem_r, rem_nx_s, rem_dec_s;
   logic [ADDR_W-1:0] addr_r, addr_nx_s, addr_inc_s;
   logic [15:0]       word_r, word_nx_s, hold_r, hold_nx_s;
   logic [4:0]        fld_r, fld_nx_s, fld_sh_s, cnt_r, cnt_nx_s, cnt_inc_s;
   logic              early_r, early_nx_s;
   logic              wr_en_r, wr_en_nx_s, busy_r, busy_nx_s, done_r, done_nx_s;
   logic              early_term_r, early_term_nx_s, error_r, error_nx_s;
   logic [ADDR_W-1:0] waddr_r, waddr_nx_s;
   logic [7:0]        wdata_r, wdata_nx_s, crc_byte_s;
   logic [3:0]        error_type_r, error_type_nx_s, err_code_s;
   logic              crc_clr_s, crc_vld_s, err_s, pre_ok_s, carry_s;
   logic [1:0]        pre_s;
   logic [4:0]        crc_s;

   assign cnt_inc_s  = cnt_r + {4'd0, i_bit_valid};
   assign fld_sh_s   = {fld_r[3:0], i_sda_bit};
   assign rem_dec_s  = (rem_r != {LEN_W{1'b0}}) ? (rem_r - {{(LEN_W-1){1'b0}}, 1'b1}) : rem_r;
   assign addr_inc_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};

   ddr_crc5 #(.INIT(CRC_INIT)) u_crc5 (
      .clk        (i_sys_clk),
      .rst        (i_sys_rst),
      .clr        (crc_clr_s),
      .byte_valid (crc_vld_s),
      .byte_data  (crc_byte_s),
      .crc        (crc_s)
   );

   // next-state, datapath and registered-output decode
   always_comb begin
      state_nx_s = state_r;   rem_nx_s = rem_r;     addr_nx_s = addr_r;
      word_nx_s  = word_r;    hold_nx_s = hold_r;   fld_nx_s = fld_r;
      cnt_nx_s   = cnt_r;     early_nx_s = early_r;
      wr_en_nx_s = 1'b0;      waddr_nx_s = waddr_r; wdata_nx_s = wdata_r;
      done_nx_s  = 1'b0;      early_term_nx_s = 1'b0;
      error_nx_s = 1'b0;      error_type_nx_s = error_type_r;
      busy_nx_s  = 1'b0;      crc_clr_s = 1'b0;     crc_vld_s = 1'b0;
      crc_byte_s = 8'h00;     err_s = 1'b0;         err_code_s = ERR_NONE;
      pre_ok_s   = 1'b0;      carry_s = 1'b0;       pre_s = 2'b00;

      case (state_r)
         ST_IDLE: begin
            if (i_start) begin
               state_nx_s = ST_PREAMBLE;  rem_nx_s = i_data_len;  addr_nx_s = i_base_addr;
               crc_clr_s  = 1'b1;         early_nx_s = 1'b0;      cnt_nx_s = 5'd0;
               fld_nx_s   = 5'd0;         error_type_nx_s = ERR_NONE;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_PREAMBLE: begin
            // both preamble bits may already have landed during the commit cycles
            if (cnt_r == 5'd2) begin
               pre_ok_s = 1'b1;  pre_s = fld_r[1:0];  carry_s = i_bit_valid;
            end else if (i_bit_valid && (cnt_r == 5'd1)) begin
               pre_ok_s = 1'b1;  pre_s = {fld_r[0], i_sda_bit};
            end else if (i_bit_valid) begin
               fld_nx_s = fld_sh_s;  cnt_nx_s = cnt_inc_s;
            end else begin
               cnt_nx_s = cnt_r;
            end
            if (pre_ok_s) begin
               cnt_nx_s  = carry_s ? 5'd1 : 5'd0;
               fld_nx_s  = {4'd0, carry_s & i_sda_bit};
               word_nx_s = {15'd0, carry_s & i_sda_bit};
               if ((pre_s == PRE_DATA) && (rem_r != {LEN_W{1'b0}})) begin
                  state_nx_s = ST_DATA;
               end else if (pre_s == PRE_CRC) begin
                  state_nx_s = ST_CRC_TOKEN;
                  early_nx_s = (rem_r != {LEN_W{1'b0}});
               end else begin
                  err_s = 1'b1;  err_code_s = ERR_FRAME;
               end
            end else begin
               state_nx_s = ST_PREAMBLE;
            end
         end
         ST_DATA: begin
            if (i_bit_valid) begin
               word_nx_s = {word_r[14:0], i_sda_bit};
               if (cnt_r == 5'd15) begin
                  state_nx_s = ST_PARITY;  cnt_nx_s = 5'd0;  fld_nx_s = 5'd0;
               end else begin
                  cnt_nx_s = cnt_inc_s;
               end
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
         ST_PARITY: begin
            if (i_bit_valid && (cnt_r == 5'd1)) begin
               if ({fld_r[0], i_sda_bit} == word_parity(word_r)) begin
                  state_nx_s = ST_COMMIT_HI;  hold_nx_s = word_r;
                  cnt_nx_s   = 5'd0;          fld_nx_s  = 5'd0;
                  wr_en_nx_s = 1'b1;          waddr_nx_s = addr_r;  wdata_nx_s = word_r[15:8];
                  addr_nx_s  = addr_inc_s;    rem_nx_s   = rem_dec_s;
               end else begin
                  err_s = 1'b1;  err_code_s = ERR_PARITY;
               end
            end else if (i_bit_valid) begin
               fld_nx_s = fld_sh_s;  cnt_nx_s = cnt_inc_s;
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
         ST_COMMIT_HI, ST_COMMIT_LO: begin
            crc_vld_s = 1'b1;
            if (state_r == ST_COMMIT_HI) begin
               // low byte of an odd-length frame is padding: CRC only, no write
               crc_byte_s = hold_r[15:8];  state_nx_s = ST_COMMIT_LO;
               wr_en_nx_s = (rem_r != {LEN_W{1'b0}});
               waddr_nx_s = addr_r;        wdata_nx_s = hold_r[7:0];
               addr_nx_s  = addr_inc_s;    rem_nx_s   = rem_dec_s;
            end else begin
               crc_byte_s = hold_r[7:0];   state_nx_s = ST_PREAMBLE;
            end
            if (i_bit_valid && (cnt_r < 5'd2)) begin
               fld_nx_s = fld_sh_s;  cnt_nx_s = cnt_inc_s;
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
         ST_CRC_TOKEN: begin
            if (i_bit_valid && (cnt_r == 5'd3)) begin
               if ({fld_r[2:0], i_sda_bit} == CRC_TOKEN) begin
                  state_nx_s = ST_CRC_VAL;  cnt_nx_s = 5'd0;  fld_nx_s = 5'd0;
               end else begin
                  err_s = 1'b1;  err_code_s = ERR_FRAME;
               end
            end else if (i_bit_valid) begin
               fld_nx_s = fld_sh_s;  cnt_nx_s = cnt_inc_s;
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
         ST_CRC_VAL: begin
            if (i_bit_valid) begin
               fld_nx_s = fld_sh_s;
               if (cnt_r == 5'd4) begin
                  state_nx_s = ST_CHECK;  cnt_nx_s = 5'd0;
               end else begin
                  cnt_nx_s = cnt_inc_s;
               end
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
         ST_CHECK: begin
            if (fld_r == crc_s) begin
               state_nx_s = ST_IDLE;  done_nx_s = 1'b1;  early_term_nx_s = early_r;
            end else begin
               err_s = 1'b1;  err_code_s = ERR_CRC;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase

      if (err_s) begin
         state_nx_s = ST_IDLE;  error_nx_s = 1'b1;  error_type_nx_s = err_code_s;  wr_en_nx_s = 1'b0;
      end else begin
         error_nx_s = 1'b0;
      end

      if (i_abort) begin
         state_nx_s = ST_IDLE;  wr_en_nx_s = 1'b0;  waddr_nx_s = {ADDR_W{1'b0}};  wdata_nx_s = 8'h00;
         done_nx_s  = 1'b0;     early_term_nx_s = 1'b0;  error_nx_s = 1'b0;
         error_type_nx_s = ERR_NONE;  busy_nx_s = 1'b0;  crc_vld_s = 1'b0;
      end else begin
         busy_nx_s = (state_nx_s != ST_IDLE);
      end
   end

   // state, datapath and output registers
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         state_r <= ST_IDLE;  rem_r <= {LEN_W{1'b0}};  addr_r <= {ADDR_W{1'b0}};
         word_r <= 16'h0000;  hold_r <= 16'h0000;     fld_r <= 5'd0;  cnt_r <= 5'd0;
         early_r <= 1'b0;     wr_en_r <= 1'b0;        waddr_r <= {ADDR_W{1'b0}};
         wdata_r <= 8'h00;    busy_r <= 1'b0;         done_r <= 1'b0;
         early_term_r <= 1'b0;  error_r <= 1'b0;      error_type_r <= ERR_NONE;
      end else begin
         state_r <= state_nx_s;  rem_r <= rem_nx_s;    addr_r <= addr_nx_s;
         word_r <= word_nx_s;    hold_r <= hold_nx_s;  fld_r <= fld_nx_s;  cnt_r <= cnt_nx_s;
         early_r <= early_nx_s;  wr_en_r <= wr_en_nx_s;  waddr_r <= waddr_nx_s;
         wdata_r <= wdata_nx_s;  busy_r <= busy_nx_s;    done_r <= done_nx_s;
         early_term_r <= early_term_nx_s;  error_r <= error_nx_s;  error_type_r <= error_type_nx_s;
      end
   end

   assign o_regf_wr_en   = wr_en_r;
   assign o_regf_addr    = waddr_r;
   assign o_regf_rx_data = wdata_r;
   assign o_busy         = busy_r;
   assign o_done         = done_r;
   assign o_early_term   = early_term_r;
   assign o_error        = error_r;
   assign o_error_type   = error_type_r;

endmodule

// File: tb/tb_ddr_rx_deframer.sv
// Directed and randomized frames checked against a behavioural frame model
// (byte list, polynomial long-division CRC, cycle-accurate write/done times).
module tb_ddr_rx_deframer;
   localparam int ADDR_W = 10;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              rst, start, abort, bit_valid, sda;
   logic [LEN_W-1:0]  data_len;
   logic [ADDR_W-1:0] base;
   logic              wr_en, busy, done, early_term, error;
   logic [ADDR_W-1:0] waddr;
   logic [7:0]        wdata;
   logic [3:0]        error_type;

   always #5 clk = ~clk;

   ddr_rx_deframer dut (
      .i_sys_clk(clk), .i_sys_rst(rst), .i_start(start), .i_abort(abort),
      .i_data_len(data_len), .i_base_addr(base), .i_bit_valid(bit_valid), .i_sda_bit(sda),
      .o_regf_wr_en(wr_en), .o_regf_addr(waddr), .o_regf_rx_data(wdata), .o_busy(busy),
      .o_done(done), .o_early_term(early_term), .o_error(error), .o_error_type(error_type)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [ADDR_W-1:0] got_addr[$];
   logic [7:0]        got_data[$];
   int                got_cyc[$];
   int                done_cnt, err_cnt, done_cyc, err_cyc;
   logic              got_early;
   logic [3:0]        got_etype;

   always @(negedge clk) begin
      if (wr_en) begin
         got_addr.push_back(waddr);  got_data.push_back(wdata);  got_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt = done_cnt + 1;  done_cyc = cyc;  got_early = early_term;
      end
      if (error) begin
         err_cnt = err_cnt + 1;  err_cyc = cyc;  got_etype = error_type;
      end
   end

   logic [15:0] w_arr[8];
   int          par_cyc[8];
   int          last_bit_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_parity(input logic [15:0] w);
      logic p1, p0;
      p1 = ($countones(w & 16'hAAAA) % 2) == 1;
      p0 = ($countones(w & 16'h5555) % 2) == 0;
      return {p1, p0};
   endfunction

   // CRC as remainder of (M*x^5 + seed*x^n) mod (x^5+x^2+1), by long division
   function automatic logic [4:0] ref_crc(input int nw);
      bit         a[$];
      logic [5:0] poly;
      logic [4:0] seed, r;
      int         n;
      poly = 6'b100101;
      seed = 5'h1F;
      for (int k = 0; k < nw; k++)
         for (int i = 15; i >= 0; i--) a.push_back(w_arr[k][i]);
      n = a.size();
      for (int i = 0; i < 5; i++) a.push_back(1'b0);
      for (int i = 0; i < 5; i++) a[i] = a[i] ^ seed[4-i];
      for (int i = 0; i < n; i++)
         if (a[i]) for (int j = 0; j < 6; j++) a[i+j] = a[i+j] ^ poly[5-j];
      for (int i = 0; i < 5; i++) r[4-i] = a[n+i];
      return r;
   endfunction

   task automatic send_bit(input logic b);
      bit_valid = 1'b1;  sda = b;  last_bit_cyc = cyc;
      @(posedge clk); #1;
      bit_valid = 1'b0;  sda = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
   endtask

   task automatic start_frame(input int len, input logic [ADDR_W-1:0] b);
      got_addr.delete();  got_data.delete();  got_cyc.delete();
      done_cnt = 0;  err_cnt = 0;  got_early = 1'b0;  got_etype = 4'd0;
      data_len = len[LEN_W-1:0];  base = b;  start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   // ek: 0 clean, 1 parity error on last word, 2 CRC corrupted, 3 bad token
   task automatic run_frame(input int len, input logic [ADDR_W-1:0] b, input int nw, input int ek);
      logic [1:0]        p;
      logic [4:0]        crc_e;
      logic [3:0]        tok;
      logic [ADDR_W-1:0] ea;
      int                nw_ok, nexp, idx;
      start_frame(len, b);
      for (int k = 0; k < nw; k++) begin
         send_bit(1'b1);  send_bit(1'b0);
         for (int i = 15; i >= 0; i--) send_bit(w_arr[k][i]);
         p = ref_parity(w_arr[k]);
         if (ek == 1 && k == nw - 1) p[1] = ~p[1];
         send_bit(p[1]);  send_bit(p[0]);
         par_cyc[k] = last_bit_cyc;
      end
      if (ek != 1) begin
         send_bit(1'b0);  send_bit(1'b1);
         tok = (ek == 3) ? 4'hA : 4'hC;
         for (int i = 3; i >= 0; i--) send_bit(tok[i]);
         if (ek != 3) begin
            crc_e = ref_crc(nw);
            if (ek == 2) crc_e[0] = ~crc_e[0];
            for (int i = 4; i >= 0; i--) send_bit(crc_e[i]);
         end
      end
      for (int i = 0; i < 12 && (done_cnt + err_cnt) == 0; i++) begin @(posedge clk); #1; end
      repeat (3) begin @(posedge clk); #1; end

      nw_ok = (ek == 1) ? nw - 1 : nw;
      nexp = 0;
      for (int k = 0; k < nw_ok; k++)
         for (int j = 0; j < 2; j++) if (2 * k + j < len) nexp++;
      chk("write_count", got_addr.size(), nexp);
      for (int i = 0; i < nexp && i < got_addr.size(); i++) begin
         idx = i;
         ea = b + idx[ADDR_W-1:0];
         chk("write_addr", {22'd0, got_addr[i]}, {22'd0, ea});
         chk("write_data", {24'd0, got_data[i]},
             {24'd0, (i % 2 == 0) ? w_arr[i/2][15:8] : w_arr[i/2][7:0]});
         chk("write_cycle", got_cyc[i], par_cyc[i/2] + 1 + (i % 2));
      end
      chk("done_pulses", done_cnt, (ek == 0) ? 1 : 0);
      chk("error_pulses", err_cnt, (ek == 0) ? 0 : 1);
      chk("error_type_held", {28'd0, error_type}, ek);
      if (ek != 0) chk("error_type_pulse", {28'd0, got_etype}, ek);
      if (ek == 0) begin
         chk("early_term", {31'd0, got_early}, (2 * nw < len) ? 1 : 0);
         chk("done_cycle", done_cyc, last_bit_cyc + 2);
      end
      if (ek == 2) chk("crc_err_cycle", err_cyc, last_bit_cyc + 2);
      chk("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int len, nw, ek;
      rst = 1'b1;  start = 1'b0;  abort = 1'b0;  bit_valid = 1'b0;  sda = 1'b0;
      data_len = '0;  base = '0;  done_cnt = 0;  err_cnt = 0;
      repeat (2) begin @(posedge clk); #1; end
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_error_type", {28'd0, error_type}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      w_arr[0] = 16'hA55A;
      run_frame(2, 10'h010, 1, 0);
      w_arr[0] = 16'h1234;  w_arr[1] = 16'h56FF;
      run_frame(3, 10'h020, 2, 0);
      w_arr[0] = 16'hA55A;
      run_frame(2, 10'h010, 1, 1);
      w_arr[0] = 16'hC3E1;
      run_frame(4, 10'h040, 1, 0);
      run_frame(2, 10'h050, 1, 2);
      run_frame(2, 10'h060, 1, 3);
      w_arr[1] = 16'h0F1E;
      run_frame(4, 10'h3FE, 2, 0);

      // reset in the middle of a data word
      start_frame(2, 10'h000);
      send_bit(1'b1);  send_bit(1'b0);
      for (int i = 0; i < 9; i++) send_bit(i[0]);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_error", {31'd0, error}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_no_writes", got_addr.size(), 32'd0);
      run_frame(0, 10'h100, 0, 0);

      // abort mid-frame
      w_arr[0] = 16'h5AA5;
      start_frame(2, 10'h080);
      send_bit(1'b1);  send_bit(1'b0);  send_bit(1'b1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      repeat (5) begin @(posedge clk); #1; end
      chk("abort_no_done", done_cnt, 32'd0);
      chk("abort_no_error", err_cnt, 32'd0);

      for (int t = 0; t < 20; t++) begin
         len = $urandom_range(0, 7);
         nw  = (len == 0) ? 0 : $urandom_range(1, (len + 1) / 2);
         ek  = $urandom_range(0, 3);
         if (ek == 1 && nw == 0) ek = 0;
         for (int k = 0; k < 8; k++) w_arr[k] = 16'($urandom);
         run_frame(len, 10'($urandom), nw, ek);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
